// File: rtl/nine_adder_seq_if.sv
// nine_adder_seq_if: handshake bundle for the sequential popcount block.
//   Input side : in_valid / in_ready / in_data (9*GROUPS bits, group k = [9k+8:9k])
//   Output side: out_valid / out_ready / out_count (SUM_W bits)
//   Status     : busy (RUN or DONE), group_idx (group currently at the adder)
// The slave modport is the popcount block. The master modport is the
// producer/consumer side.
interface nine_adder_seq_if #(
  parameter int unsigned GROUPS = 8,
  parameter int unsigned SUM_W  = 7,
  parameter int unsigned IDX_W  = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [9*GROUPS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SUM_W-1:0]      out_count;
  logic                  busy;
  logic [IDX_W-1:0]      group_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, busy, group_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, busy, group_idx
  );
endinterface

// File: rtl/nine_adder_seq.sv
// nine_adder_seq: sequential population count.
// A captured 9*GROUPS-bit vector is shifted through a single nine-input
// one-bit adder, 9 bits per cycle. The per-group counts are accumulated,
// and the total is presented with a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - nine_adder_seq_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_count, busy, group_idx)
module nine_adder_seq #(
  parameter int unsigned GROUPS = 8,
  parameter int unsigned SUM_W  = 7,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  nine_adder_seq_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [9*GROUPS-1:0]   shift_q, shift_d;
  logic [SUM_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SUM_W-1:0]      out_count_q, out_count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;

  logic [3:0]            add_res;
  logic [SUM_W-1:0]      sum_next;
  logic                  last_group;

  // Shared NINE adder: nine one-bit inputs, {cout2,cout1,cout0,sum} = 0..9.
  function automatic logic [3:0] nine_add(input logic [8:0] b);
    logic [3:0] s;
    s = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      s = s + 4'(b[i]);
    end
    return s;
  endfunction

  assign add_res    = nine_add(shift_q[8:0]);
  assign sum_next   = acc_q + SUM_W'(add_res);
  assign last_group = (idx_q == IDX_W'(GROUPS - 1));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d    = bus.in_data;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        acc_d   = sum_next;
        shift_d = shift_q >> 9;
        if (last_group) begin
          // The final group is folded in directly, so the result lands on
          // the same edge as the last accumulation.
          out_count_d = sum_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = '0;
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = busy_q;
  assign bus.group_idx = idx_q;

endmodule

// File: tb/tb_nine_adder_seq.sv
// Self-checking bench for nine_adder_seq at the default configuration
// (8 groups, 72-bit vectors). Expected counts come from a plain bit-count model.
module tb_nine_adder_seq;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  nine_adder_seq_if #(.GROUPS(8), .SUM_W(7), .IDX_W(3)) b ();

  nine_adder_seq #(.GROUPS(8), .SUM_W(7), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  function automatic int ref_pop(input logic [71:0] v);
    int n = 0;
    for (int i = 0; i < 72; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  // One group result above 9 would mean a broken adder stage.
  always @(negedge clk) begin
    if (!rst && b.busy) begin
      checks++;
      if (dut.add_res > 4'd9) begin
        errors++;
        $display("FAIL adder_range: got %0d, required <= 9", dut.add_res);
      end
    end
  end

  // Runs one vector with out_ready low until the result appears. It reports the
  // count, the cycles from the accept edge to out_valid, whether in_ready stayed
  // low, and whether group_idx stepped 0,1,2,...
  task automatic do_op(input logic [71:0] d, output int cnt, output int lat,
                       output bit rdy_low, output bit idx_ok);
    rdy_low = 1'b1; idx_ok = 1'b1; lat = 0; cnt = -1;
    @(negedge clk); b.in_valid = 1'b1; b.in_data = d; b.out_ready = 1'b0;
    @(negedge clk); b.in_valid = 1'b0; b.in_data = rand72();
    while (!b.out_valid && lat < 40) begin
      if (b.in_ready !== 1'b0) rdy_low = 1'b0;
      if (b.group_idx !== 3'(lat)) idx_ok = 1'b0;
      @(negedge clk); lat++;
    end
    if (b.out_valid) begin
      cnt = int'(b.out_count);
      if (b.in_ready !== 1'b0) rdy_low = 1'b0;
    end
    b.out_ready = 1'b1;
    @(negedge clk); b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    b.in_valid = 1'b0; b.out_ready = 1'b0; b.in_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", b.in_ready); end
    checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", b.out_valid); end
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", b.busy); end
    checks++; if (b.group_idx !== 3'd0) begin errors++; $display("FAIL reset_group_idx: got %0d, required 0", b.group_idx); end
    checks++; if (b.out_count !== 7'd0) begin errors++; $display("FAIL reset_out_count: got %0d, required 0", b.out_count); end
  endtask

  task automatic test_zero();
    int cnt, lat; bit rl, io;
    do_op(72'h0, cnt, lat, rl, io);
    checks++; if (cnt != 0) begin errors++; $display("FAIL zero_count: got %0d, required 0", cnt); end
    checks++; if (lat != G) begin errors++; $display("FAIL zero_latency: got %0d, required %0d", lat, G); end
    checks++; if (!rl) begin errors++; $display("FAIL zero_in_ready_low: got 0, required 1"); end
  endtask

  task automatic test_all_ones();
    int cnt, lat; bit rl, io;
    do_op(72'hFF_FFFF_FFFF_FFFF_FFFF, cnt, lat, rl, io);
    checks++; if (cnt != 72) begin errors++; $display("FAIL ones_count: got %0d, required 72", cnt); end
    checks++; if (!io) begin errors++; $display("FAIL ones_group_idx_steps: got 0, required 1"); end
    checks++; if (lat != G) begin errors++; $display("FAIL ones_latency: got %0d, required %0d", lat, G); end
  endtask

  task automatic test_patterns();
    logic [71:0] pats [4];
    int exp [4];
    int cnt, lat; bit rl, io;
    pats[0] = 72'h1FF << 27;               exp[0] = 9;
    pats[1] = 72'hAA_AAAA_AAAA_AAAA_AAAA;  exp[1] = 36;
    pats[2] = {1'b1, 70'h0, 1'b1};         exp[2] = 2;
    pats[3] = 72'h1FF << 63;               exp[3] = 9;
    for (int i = 0; i < 4; i++) begin
      do_op(pats[i], cnt, lat, rl, io);
      checks++;
      if (cnt != exp[i]) begin errors++; $display("FAIL pattern%0d_count: got %0d, required %0d", i, cnt, exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [71:0] d1, d2;
    int n;
    d1 = rand72(); d2 = rand72();
    @(negedge clk); b.in_valid = 1'b1; b.in_data = d1; b.out_ready = 1'b0;
    @(negedge clk); b.in_valid = 1'b0;
    n = 0;
    while (!b.out_valid && n < 40) begin @(negedge clk); n++; end
    checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL bp_result_ready: got %b, required 1", b.out_valid); end
    b.in_valid = 1'b1; b.in_data = d2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b, required 1", i, b.out_valid); end
      checks++; if (int'(b.out_count) != ref_pop(d1)) begin errors++; $display("FAIL bp_hold_count%0d: got %0d, required %0d", i, b.out_count, ref_pop(d1)); end
      checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b, required 0", i, b.in_ready); end
    end
    b.out_ready = 1'b1;
    @(negedge clk); b.out_ready = 1'b0;
    checks++; if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got in_ready=%b out_valid=%b, required 1 0", b.in_ready, b.out_valid); end
    @(negedge clk); b.in_valid = 1'b0; b.in_data = rand72();
    checks++; if (b.busy !== 1'b1 || b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_pending_accept: got busy=%b in_ready=%b, required 1 0", b.busy, b.in_ready); end
    n = 0;
    while (!b.out_valid && n < 40) begin @(negedge clk); n++; end
    checks++; if (!b.out_valid || int'(b.out_count) != ref_pop(d2)) begin errors++; $display("FAIL bp_pending_count: got %0d (valid %b), required %0d", b.out_count, b.out_valid, ref_pop(d2)); end
    b.out_ready = 1'b1;
    @(negedge clk); b.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [71:0] d;
    int n, cnt, lat; bit rl, io, seen;
    d = rand72();
    @(negedge clk); b.in_valid = 1'b1; b.in_data = d;
    @(negedge clk); b.in_valid = 1'b0;
    n = 0;
    while (b.group_idx !== 3'd4 && n < 20) begin @(negedge clk); n++; end
    checks++; if (b.group_idx !== 3'd4) begin errors++; $display("FAIL rstrun_reach_idx4: got %0d, required 4", b.group_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy: got %b, required 0", b.busy); end
    checks++; if (b.group_idx !== 3'd0) begin errors++; $display("FAIL rstrun_group_idx: got %0d, required 0", b.group_idx); end
    checks++; if (b.out_count !== 7'd0) begin errors++; $display("FAIL rstrun_out_count: got %0d, required 0", b.out_count); end
    checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL rstrun_in_ready: got %b, required 1", b.in_ready); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < G + 4; i++) begin
      @(negedge clk);
      if (b.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstrun_no_result: got out_valid=1, required 0"); end
    d = rand72();
    do_op(d, cnt, lat, rl, io);
    checks++; if (cnt != ref_pop(d)) begin errors++; $display("FAIL rstrun_fresh_count: got %0d, required %0d", cnt, ref_pop(d)); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] vec [20];
    int exp_q [$];
    int cyc, acc_n, res_n, last_acc;
    bit prev_rdy;
    for (int i = 0; i < 20; i++) vec[i] = rand72();
    cyc = 0; acc_n = 0; res_n = 0; last_acc = 0;
    @(negedge clk); b.in_valid = 1'b1; b.in_data = vec[0]; b.out_ready = 1'b1;
    prev_rdy = b.in_ready && b.in_valid;
    while (res_n < 20 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (prev_rdy && acc_n < 20) begin
        exp_q.push_back(ref_pop(vec[acc_n]));
        if (acc_n > 0) begin
          checks++;
          if (cyc - last_acc != G + 2) begin errors++; $display("FAIL b2b_spacing%0d: got %0d, required %0d", acc_n, cyc - last_acc, G + 2); end
        end
        last_acc = cyc;
        acc_n++;
        if (acc_n < 20) b.in_data = vec[acc_n];
        else b.in_valid = 1'b0;
      end
      if (b.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_count%0d: got %0d, required none", res_n, b.out_count);
        end else begin
          if (int'(b.out_count) != exp_q[0]) begin errors++; $display("FAIL b2b_count%0d: got %0d, required %0d", res_n, b.out_count, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        res_n++;
      end
      prev_rdy = b.in_ready && b.in_valid;
    end
    checks++; if (res_n != 20) begin errors++; $display("FAIL b2b_results: got %0d, required 20", res_n); end
    b.in_valid = 1'b0; b.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_all_ones();
    test_patterns();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
